branch_resolve_unit: RTL
========================

Name: branch_resolve_unit

Overview:
- Parametrised, registered branch/jump resolution stage for the RV32IM pipeline.
- Evaluates the branch condition and computes the target address.
- Compares the outcome against the front-end prediction and raises a mispredict redirect.
- Holds a multi-cycle flush window and keeps saturating branch/mispredict statistics.
- Sits at the EX/MEM boundary. Its outputs feed PC select and the IF/ID and ID/EX flush inputs.

Parameters:
- XLEN, 32, datapath/address width.
- FLUSH_CYCLES, 2, cycles FLUSH stays high after a mispredict (1..15).
- CNT_W, 16, width of each statistics counter.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RESET  in  1  asynchronous, active-high reset.
- STALL  in  1  pipeline stall; freezes result capture.
- BR_VALID  in  1  instruction in EX is a branch or jump.
- BR_TYPE  in  4  bit3 = jump (JAL/JALR); bits2:0 = funct3.
- JALR_SEL  in  1  target base is DATA1 (JALR) instead of PC.
- DATA1, DATA2  in  XLEN  rs1, rs2 operand values.
- PC  in  XLEN  PC of the branch.
- IMM  in  XLEN  sign-extended offset.
- PRED_TAKEN  in  1  front-end prediction (0 under static not-taken).
- PRED_TARGET  in  XLEN  predicted target.
- CNT_CLR  in  1  synchronous clear of both counters.
- RES_VALID  out  1  registered result is valid this cycle.
- BR_TAKEN  out  1  resolved direction.
- MISPREDICT  out  1  resolved outcome differs from prediction.
- ILLEGAL_BR  out  1  BR_VALID with a reserved funct3 and bit3=0.
- REDIRECT_PC  out  XLEN  correct next PC.
- FLUSH  out  1  squash younger stages.
- BRANCH_COUNT  out  CNT_W  resolved branches/jumps.
- MISPRED_COUNT  out  CNT_W  mispredicts.

Behaviour:
- Reset: every output and internal register is 0, flush counter included.
- Condition evaluation, combinational:
  - BR_TYPE[3]=1: always taken.
  - Otherwise funct3 decodes as: 000 EQ, 001 NE, 100 signed LT, 101 signed GE, 110 unsigned LT, 111 unsigned GE.
  - Signed compares use $signed on both operands.
  - funct3 010 and 011: not taken, ILLEGAL_BR=1.
  - funct3 000 (BEQ) is a valid branch and must not be masked as "no branch".
- Target: (JALR_SEL ? DATA1 : PC) + IMM, modulo 2^XLEN. When JALR_SEL=1, bit0 is forced to 0.
- Fall-through: PC+4, wraps modulo 2^XLEN.
- Mispredict is true when either:
  - taken != PRED_TAKEN, or
  - taken && PRED_TAKEN && target != PRED_TARGET.
- Latency: one cycle. An evaluation is captured on a CLK edge when BR_VALID && !STALL && flush_cnt==0. The next cycle then shows:
  - RES_VALID=1 and BR_TAKEN, MISPREDICT, ILLEGAL_BR.
  - REDIRECT_PC = taken ? target : PC+4.
- Cycles without a capture: RES_VALID, MISPREDICT and ILLEGAL_BR are 0. BR_TAKEN and REDIRECT_PC hold their last values.
- Flush window (flush_cnt, width ceil(log2(FLUSH_CYCLES+1))):
  - A captured mispredict loads FLUSH_CYCLES.
  - The counter decrements every cycle it is nonzero, STALL included.
  - FLUSH = (flush_cnt != 0).
  - FLUSH rises in the same cycle as MISPREDICT and stays high for exactly FLUSH_CYCLES cycles.
- BR_VALID during the flush window belongs to a squashed instruction. It is ignored: no result, no count, no new flush.
- Counters:
  - BRANCH_COUNT increments on every capture; MISPRED_COUNT increments on each captured mispredict.
  - Both saturate at all-ones.
  - CNT_CLR has priority over an increment in the same cycle; the result is 0.
- STALL=1: no capture, RES_VALID=0, counters hold.
- Asynchronous RESET mid-window: FLUSH drops immediately and counters clear.

Decomposition:
- Shared package `rv_branch_pkg`:
  - funct3 constants F3_BEQ..F3_BGEU.
  - BR_JUMP_BIT index.
  - Instruction byte increment constant (4).
- Sub-module `branch_cond` (combinational: DATA1, DATA2, BR_TYPE -> taken, illegal), reusable by a future early-resolve stage.
- Top level holds the target adders, prediction compare, output registers, flush counter and statistics counters.

Test Plan:
- BEQ, DATA1=DATA2=5, PC=0x100, IMM=0x20, PRED_TAKEN=0 -> next cycle BR_TAKEN=1, MISPREDICT=1, REDIRECT_PC=0x120, FLUSH high exactly 2 cycles, MISPRED_COUNT=1.
- BLT DATA1=0xFFFFFFFF, DATA2=1 -> taken; BLTU with the same operands -> not taken, REDIRECT_PC=PC+4, MISPREDICT=0 when PRED_TAKEN=0.
- JALR DATA1=0x2003, IMM=0, PRED_TAKEN=1, PRED_TARGET=0x2002 -> target 0x2002, MISPREDICT=0, no FLUSH; PRED_TARGET=0x2000 -> MISPREDICT=1.
- Mispredict followed by BR_VALID on the next two cycles -> those ignored: BRANCH_COUNT +1 total, FLUSH not extended; capture resumes on the third cycle.
- funct3=010 with BR_VALID -> ILLEGAL_BR=1, BR_TAKEN=0; STALL=1 with BR_VALID -> RES_VALID=0 and counters unchanged.
- CNT_W=4: 16 captured branches -> BRANCH_COUNT saturates at 15. CNT_CLR together with a capture -> 0. Assert RESET while FLUSH=1 -> all outputs 0 without waiting for CLK.

Source files
------------

// File: rtl/rv_branch_pkg.sv
// Shared branch-resolution definitions: funct3 encodings, jump flag position,
// and instruction size used for the fall-through address.
package rv_branch_pkg;

  typedef enum logic [2:0] {
    F3_BEQ  = 3'b000,
    F3_BNE  = 3'b001,
    F3_BLT  = 3'b100,
    F3_BGE  = 3'b101,
    F3_BLTU = 3'b110,
    F3_BGEU = 3'b111
  } br_funct3_e;

  localparam int unsigned BR_JUMP_BIT = 3;
  localparam int unsigned INSN_BYTES  = 4;

endpackage

// File: rtl/branch_resolve_unit_cond.sv
// Combinational branch condition evaluator; shared with future early-resolve logic.
module branch_cond
  import rv_branch_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] DATA1,
  input  logic [XLEN-1:0] DATA2,
  input  logic [3:0]      BR_TYPE,
  output logic            taken,
  output logic            illegal
);

  always_comb begin
    taken   = 1'b0;
    illegal = 1'b0;
    if (BR_TYPE[BR_JUMP_BIT]) begin
      taken = 1'b1;
    end else begin
      case (BR_TYPE[2:0])
        F3_BEQ:  taken = (DATA1 == DATA2);
        F3_BNE:  taken = (DATA1 != DATA2);
        F3_BLT:  taken = ($signed(DATA1) <  $signed(DATA2));
        F3_BGE:  taken = ($signed(DATA1) >= $signed(DATA2));
        F3_BLTU: taken = (DATA1 <  DATA2);
        F3_BGEU: taken = (DATA1 >= DATA2);
        default: illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// EX/MEM branch resolution: registered outcome, mispredict redirect,
// fixed-length flush window and saturating branch statistics.
module branch_resolve_unit
  import rv_branch_pkg::*;
#(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             STALL,
  input  logic             BR_VALID,
  input  logic [3:0]       BR_TYPE,
  input  logic             JALR_SEL,
  input  logic [XLEN-1:0]  DATA1,
  input  logic [XLEN-1:0]  DATA2,
  input  logic [XLEN-1:0]  PC,
  input  logic [XLEN-1:0]  IMM,
  input  logic             PRED_TAKEN,
  input  logic [XLEN-1:0]  PRED_TARGET,
  input  logic             CNT_CLR,
  output logic             RES_VALID,
  output logic             BR_TAKEN,
  output logic             MISPREDICT,
  output logic             ILLEGAL_BR,
  output logic [XLEN-1:0]  REDIRECT_PC,
  output logic             FLUSH,
  output logic [CNT_W-1:0] BRANCH_COUNT,
  output logic [CNT_W-1:0] MISPRED_COUNT
);

  localparam int unsigned FC_W = $clog2(FLUSH_CYCLES + 1);
  localparam logic [FC_W-1:0] FC_LOAD = FC_W'(FLUSH_CYCLES);

  logic            cond_taken, cond_illegal;
  logic [XLEN-1:0] target, fall_through, base;
  logic            mispred_c, capture;

  logic            res_valid_q, res_valid_d;
  logic            br_taken_q, br_taken_d;
  logic            mispredict_q, mispredict_d;
  logic            illegal_q, illegal_d;
  logic [XLEN-1:0] redirect_q, redirect_d;
  logic [FC_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
  logic [CNT_W-1:0] mp_cnt_q, mp_cnt_d;

  branch_cond #(.XLEN(XLEN)) u_cond (
    .DATA1   (DATA1),
    .DATA2   (DATA2),
    .BR_TYPE (BR_TYPE),
    .taken   (cond_taken),
    .illegal (cond_illegal)
  );

  always_comb begin
    base         = JALR_SEL ? DATA1 : PC;
    target       = base + IMM;
    if (JALR_SEL) target[0] = 1'b0;
    fall_through = PC + XLEN'(INSN_BYTES);
    mispred_c    = (cond_taken != PRED_TAKEN) ||
                   (cond_taken && PRED_TAKEN && (target != PRED_TARGET));
    // Instructions arriving inside the flush window are already squashed.
    capture      = BR_VALID && !STALL && (flush_cnt_q == '0);
  end

  always_comb begin
    res_valid_d  = capture;
    mispredict_d = capture && mispred_c;
    illegal_d    = capture && cond_illegal;
    br_taken_d   = br_taken_q;
    redirect_d   = redirect_q;
    if (capture) begin
      br_taken_d = cond_taken;
      redirect_d = cond_taken ? target : fall_through;
    end

    flush_cnt_d = flush_cnt_q;
    if (capture && mispred_c)    flush_cnt_d = FC_LOAD;
    else if (flush_cnt_q != '0)  flush_cnt_d = flush_cnt_q - 1'b1;

    br_cnt_d = br_cnt_q;
    mp_cnt_d = mp_cnt_q;
    if (CNT_CLR) begin
      br_cnt_d = '0;
      mp_cnt_d = '0;
    end else if (capture) begin
      if (br_cnt_q != '1)             br_cnt_d = br_cnt_q + 1'b1;
      if (mispred_c && mp_cnt_q != '1) mp_cnt_d = mp_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      res_valid_q  <= 1'b0;
      br_taken_q   <= 1'b0;
      mispredict_q <= 1'b0;
      illegal_q    <= 1'b0;
      redirect_q   <= '0;
      flush_cnt_q  <= '0;
      br_cnt_q     <= '0;
      mp_cnt_q     <= '0;
    end else begin
      res_valid_q  <= res_valid_d;
      br_taken_q   <= br_taken_d;
      mispredict_q <= mispredict_d;
      illegal_q    <= illegal_d;
      redirect_q   <= redirect_d;
      flush_cnt_q  <= flush_cnt_d;
      br_cnt_q     <= br_cnt_d;
      mp_cnt_q     <= mp_cnt_d;
    end
  end

  assign RES_VALID     = res_valid_q;
  assign BR_TAKEN      = br_taken_q;
  assign MISPREDICT    = mispredict_q;
  assign ILLEGAL_BR    = illegal_q;
  assign REDIRECT_PC   = redirect_q;
  assign FLUSH         = (flush_cnt_q != '0);
  assign BRANCH_COUNT  = br_cnt_q;
  assign MISPRED_COUNT = mp_cnt_q;

endmodule
